info_prefix_mapper: RTL and testbench

- Consumer stage directly downstream of the filling shift register in the information mapper.
- Each cycle it matches the low bits of the register's `b` window against a programmable prefix-free code table.
- It drives back the consumed bit count `c` in the same cycle and emits one registered symbol index per match, with valid/ready flow control and frame marking.

---
 rtl/info_prefix_mapper.sv | 146 ++++++++++++++
 tb/tb_info_prefix_mapper.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/info_prefix_mapper.sv
// info_prefix_mapper: consumes prefix-free codewords from the low end of the
// upstream shift register window, reports the consumed bit count combinationally
// and emits one registered symbol index per match with valid/ready and frame marking.
module info_prefix_mapper #(
    parameter  int MAPPER_PARALLELISM = 8,
    parameter  int NUM_SYMBOLS        = 16,
    parameter  int FRAME_SYMBOLS      = 64,
    parameter  int WARMUP_CYCLES      = 2,
    localparam int LW                 = $clog2(MAPPER_PARALLELISM),
    localparam int SW                 = $clog2(NUM_SYMBOLS),
    localparam int CW                 = MAPPER_PARALLELISM - 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [MAPPER_PARALLELISM-1:0] b,
    output logic [LW-1:0]                 c,
    input  logic                          enable,
    input  logic                          tbl_wr_en,
    input  logic [SW-1:0]                 tbl_wr_addr,
    input  logic [CW-1:0]                 tbl_wr_code,
    input  logic [LW-1:0]                 tbl_wr_len,
    output logic                          sym_valid,
    input  logic                          sym_ready,
    output logic [SW-1:0]                 sym_idx,
    output logic                          sym_last,
    output logic                          busy,
    output logic                          err
);

    localparam int WCW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam logic [WCW-1:0] WARM_LAST = WCW'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);
    localparam int FCW = (FRAME_SYMBOLS > 1) ? $clog2(FRAME_SYMBOLS) : 1;
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAME_SYMBOLS - 1);

    typedef enum logic [1:0] {
        S_WARMUP = 2'd0,
        S_IDLE   = 2'd1,
        S_RUN    = 2'd2,
        S_ERROR  = 2'd3
    } state_t;

    state_t          state;
    logic [WCW-1:0]  warm_cnt;
    logic [FCW-1:0]  frame_cnt;

    logic [CW-1:0]   tbl_code [NUM_SYMBOLS];
    logic [LW-1:0]   tbl_len  [NUM_SYMBOLS];

    logic            hit;
    logic [SW-1:0]   hit_idx;
    logic [LW-1:0]   hit_len;
    logic            cap;
    logic            tbl_open;

    // The window MSB can never be part of a codeword (length <= width-1).
    logic            unused_b_msb;
    assign unused_b_msb = b[MAPPER_PARALLELISM-1];

    // Bits below the codeword length take part in the compare; the rest are don't-care.
    function automatic logic [CW-1:0] len_mask(input logic [LW-1:0] len);
        logic [CW-1:0] m;
        for (int k = 0; k < CW; k++) begin
            m[k] = (k < int'(len));
        end
        return m;
    endfunction

    // Priority match: scan from the top so the lowest matching entry is left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_len = '0;
        for (int i = NUM_SYMBOLS - 1; i >= 0; i--) begin
            if ((tbl_len[i] != '0) &&
                (((b[CW-1:0] ^ tbl_code[i]) & len_mask(tbl_len[i])) == '0)) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
                hit_len = tbl_len[i];
            end
        end
    end

    // A symbol is taken only when running, matched and the output slot is free;
    // otherwise the upstream register must not shift.
    assign cap      = (state == S_RUN) && hit && (!sym_valid || sym_ready);
    assign c        = cap ? hit_len : '0;
    assign tbl_open = (state == S_IDLE) || (state == S_WARMUP);
    assign busy     = (state == S_RUN);
    assign err      = (state == S_ERROR);

    // Code table: writable only while not decoding; reset disables every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SYMBOLS; i++) begin
                tbl_len[i] <= '0;
            end
        end else if (tbl_wr_en && tbl_open) begin
            tbl_code[tbl_wr_addr] <= tbl_wr_code;
            tbl_len[tbl_wr_addr]  <= tbl_wr_len;
        end
    end

    // Control FSM: warm-up delay, idle/run handshake, absorbing error on no-match.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_WARMUP;
            warm_cnt <= '0;
        end else begin
            case (state)
                S_WARMUP: begin
                    if (warm_cnt == WARM_LAST) state <= S_IDLE;
                    else                       warm_cnt <= warm_cnt + WCW'(1);
                end
                S_IDLE: begin
                    if (enable) state <= S_RUN;
                end
                S_RUN: begin
                    if (!hit)
                        state <= S_ERROR;
                    else if (cap && (frame_cnt == FRAME_LAST) && !enable)
                        state <= S_IDLE;
                end
                S_ERROR: state <= S_ERROR;
                default: state <= S_WARMUP;
            endcase
        end
    end

    // Output slot and frame position: load on capture, drain on ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            sym_valid <= 1'b0;
            sym_idx   <= '0;
            sym_last  <= 1'b0;
            frame_cnt <= '0;
        end else if (cap) begin
            sym_valid <= 1'b1;
            sym_idx   <= hit_idx;
            sym_last  <= (frame_cnt == FRAME_LAST);
            frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + FCW'(1);
        end else if (sym_ready) begin
            sym_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_info_prefix_mapper.sv
// Directed bench for info_prefix_mapper: decode, backpressure, framing,
// priority, error handling and reset behaviour with hand-computed vectors.
module tb_info_prefix_mapper;

    logic       clk;
    logic       reset;
    logic [7:0] b;
    logic [2:0] c;
    logic       enable;
    logic       tbl_wr_en;
    logic [1:0] tbl_wr_addr;
    logic [6:0] tbl_wr_code;
    logic [2:0] tbl_wr_len;
    logic       sym_valid;
    logic       sym_ready;
    logic [1:0] sym_idx;
    logic       sym_last;
    logic       busy;
    logic       err;

    int n_chk  = 0;
    int n_fail = 0;

    info_prefix_mapper #(
        .MAPPER_PARALLELISM(8),
        .NUM_SYMBOLS(4),
        .FRAME_SYMBOLS(4),
        .WARMUP_CYCLES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .b(b),
        .c(c),
        .enable(enable),
        .tbl_wr_en(tbl_wr_en),
        .tbl_wr_addr(tbl_wr_addr),
        .tbl_wr_code(tbl_wr_code),
        .tbl_wr_len(tbl_wr_len),
        .sym_valid(sym_valid),
        .sym_ready(sym_ready),
        .sym_idx(sym_idx),
        .sym_last(sym_last),
        .busy(busy),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_b(input logic [7:0] v);
        b = v;
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [6:0] code, input logic [2:0] len);
        tbl_wr_en   = 1'b1;
        tbl_wr_addr = a;
        tbl_wr_code = code;
        tbl_wr_len  = len;
        tick();
        tbl_wr_en   = 1'b0;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_c"}, 32'(c), 0);
        check({tag, "_valid"}, 32'(sym_valid), 0);
        check({tag, "_idx"}, 32'(sym_idx), 0);
        check({tag, "_last"}, 32'(sym_last), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_err"}, 32'(err), 0);
    endtask

    initial begin
        reset = 1'b1; b = 8'h00; enable = 1'b0; sym_ready = 1'b0;
        tbl_wr_en = 1'b0; tbl_wr_addr = '0; tbl_wr_code = '0; tbl_wr_len = '0;
        tick();
        tick();
        check_reset_outs("rst0");

        // warm-up (2 cycles), then IDLE; load the common table
        reset = 1'b0;
        tick();
        tick();
        wr(2'd0, 7'h00, 3'd1);
        wr(2'd1, 7'h01, 3'd2);
        wr(2'd2, 7'h03, 3'd3);
        wr(2'd3, 7'h07, 3'd3);

        // basic decode
        sym_ready = 1'b1; enable = 1'b1;
        set_b(8'h06);
        check("idle_c", 32'(c), 0);
        tick();
        check("run_busy", 32'(busy), 1);
        check("dec0_c", 32'(c), 1);
        tick();
        check("dec0_valid", 32'(sym_valid), 1);
        check("dec0_idx", 32'(sym_idx), 0);
        set_b(8'hFD);
        check("dec1_c", 32'(c), 2);
        tick();
        check("dec1_idx", 32'(sym_idx), 1);
        set_b(8'hFF);
        check("dec2_c", 32'(c), 3);
        tick();
        check("dec2_idx", 32'(sym_idx), 3);
        check("dec2_last", 32'(sym_last), 0);

        // backpressure: slot full, nothing consumed
        sym_ready = 1'b0;
        set_b(8'h06);
        for (int i = 0; i < 5; i++) begin
            check("stall_c", 32'(c), 0);
            check("stall_valid", 32'(sym_valid), 1);
            check("stall_idx", 32'(sym_idx), 3);
            tick();
        end
        sym_ready = 1'b1;
        #1;
        check("release_c", 32'(c), 1);
        tick();
        check("release_idx", 32'(sym_idx), 0);
        check("wrap_last", 32'(sym_last), 1);

        // frame of four with enable dropped during the 2nd symbol
        set_b(8'h06);
        check("fr1_c", 32'(c), 1);
        tick();
        check("fr1_idx", 32'(sym_idx), 0);
        check("fr1_last", 32'(sym_last), 0);
        enable = 1'b0;
        set_b(8'hFD);
        check("fr2_c", 32'(c), 2);
        tick();
        check("fr2_idx", 32'(sym_idx), 1);
        set_b(8'hFF);
        check("fr3_c", 32'(c), 3);
        tick();
        check("fr3_idx", 32'(sym_idx), 3);
        check("fr3_last", 32'(sym_last), 0);
        check("fr3_busy", 32'(busy), 1);
        set_b(8'h06);
        check("fr4_c", 32'(c), 1);
        tick();
        check("fr4_idx", 32'(sym_idx), 0);
        check("fr4_last", 32'(sym_last), 1);
        check("fr4_valid", 32'(sym_valid), 1);
        check("stop_busy", 32'(busy), 0);
        check("stop_c", 32'(c), 0);
        tick();
        check("drain_valid", 32'(sym_valid), 0);

        // priority: overlap e1 with e0, written in the same cycle as enable
        tbl_wr_en = 1'b1; tbl_wr_addr = 2'd1; tbl_wr_code = 7'h00; tbl_wr_len = 3'd2;
        enable = 1'b1;
        tick();
        tbl_wr_en = 1'b0;
        set_b(8'h00);
        check("prio_c", 32'(c), 1);
        tick();
        check("prio_idx", 32'(sym_idx), 0);
        check("prio_valid", 32'(sym_valid), 1);

        // no match while a symbol is pending
        sym_ready = 1'b0;
        set_b(8'h05);
        check("nomatch_c", 32'(c), 0);
        tick();
        check("nomatch_err", 32'(err), 1);
        check("nomatch_busy", 32'(busy), 0);
        check("pend_valid", 32'(sym_valid), 1);
        sym_ready = 1'b1;
        tick();
        check("errdrain_valid", 32'(sym_valid), 0);
        wr(2'd0, 7'h01, 3'd1);
        check("err_hold", 32'(err), 1);
        check("err_c", 32'(c), 0);
        tick();
        check("err_hold2", 32'(err), 1);
        check("err_valid", 32'(sym_valid), 0);

        // reset clears error; warm-up blocks consumption; empty table errors
        reset = 1'b1; enable = 1'b1; set_b(8'h06);
        tick();
        reset = 1'b0;
        check_reset_outs("rst1");
        tick();
        check("warm_c", 32'(c), 0);
        check("warm_busy", 32'(busy), 0);
        tick();
        check("idle2_c", 32'(c), 0);
        check("idle2_busy", 32'(busy), 0);
        tick();
        check("empty_busy", 32'(busy), 1);
        check("empty_c", 32'(c), 0);
        tick();
        check("empty_err", 32'(err), 1);
        check("empty_valid", 32'(sym_valid), 0);

        // reset with a pending symbol
        reset = 1'b1; enable = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        tick();
        wr(2'd2, 7'h03, 3'd3);
        enable = 1'b1; sym_ready = 1'b0;
        set_b(8'hFB);
        tick();
        check("mid_c", 32'(c), 3);
        tick();
        check("mid_valid", 32'(sym_valid), 1);
        check("mid_idx", 32'(sym_idx), 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outs("rst2");
        tick();
        check("warm2_c", 32'(c), 0);
        tick();
        check("warm2_idle_c", 32'(c), 0);
        tick();
        check("cleared_busy", 32'(busy), 1);
        check("cleared_c", 32'(c), 0);
        tick();
        check("cleared_err", 32'(err), 1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
